// File: rtl/ex_stage_md.sv
// rtl/ex_stage_md.sv - execute stage: ALU, single-cycle multiply, iterative restoring divide
module ex_stage_md #(
    parameter int XLEN  = 32,
    parameter int MD_EN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic            op1_sel,
    input  logic            op2_sel,
    input  logic [3:0]      alu_ctrl,
    input  logic            md_en,
    input  logic [2:0]      md_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int SHW = (XLEN == 64) ? 6 : 5;
    localparam int CW  = $clog2(XLEN + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]      state;
    logic [CW-1:0]   count;

    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [SHW-1:0]  shamt;
    logic            accept;
    logic            is_div;

    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] mul_res;
    logic [XLEN-1:0] single_res;
    logic            a_sx;
    logic            b_sx;
    logic [2*XLEN-1:0] mul_a;
    logic [2*XLEN-1:0] mul_b;
    logic [2*XLEN-1:0] prod;

    // Divider working state: quotient shifts in from the right while the
    // dividend magnitude shifts out of its top into the partial remainder.
    logic [XLEN-1:0] dq;
    logic [XLEN-1:0] dr;
    logic [XLEN-1:0] dd;
    logic [XLEN-1:0] d_a;
    logic            d_negq;
    logic            d_negr;
    logic            d_rem;
    logic            d_zero;
    logic            d_ovf;

    logic            sgn;
    logic            neg_a;
    logic            neg_b;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic [XLEN:0]   shifted;
    logic            ge;
    logic [XLEN-1:0] diff;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;
    logic [XLEN-1:0] fix_res;

    assign a      = op1_sel ? pc : op1;
    assign b      = op2_sel ? imm : op2;
    assign shamt  = b[SHW-1:0];
    assign in_ready = (state == S_IDLE) && (!out_valid || out_ready) && !flush;
    assign accept = in_valid && in_ready;
    assign is_div = md_en && md_op[2] && (MD_EN != 0);
    assign busy   = (state == S_DIV) || (state == S_FIX);

    // ALU operation decode; unassigned codes yield zero
    always_comb begin
        alu_res = '0;
        case (alu_ctrl)
            4'd0:    alu_res = a + b;
            4'd1:    alu_res = a - b;
            4'd2:    alu_res = a << shamt;
            4'd3:    alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            4'd4:    alu_res = {{(XLEN-1){1'b0}}, (a < b)};
            4'd5:    alu_res = a ^ b;
            4'd6:    alu_res = a >> shamt;
            4'd7:    alu_res = $unsigned($signed(a) >>> shamt);
            4'd8:    alu_res = a | b;
            4'd9:    alu_res = a & b;
            4'd10:   alu_res = b;
            default: alu_res = '0;
        endcase
    end

    // Multiply: extend each operand to 2*XLEN per signedness, keep low or high half
    always_comb begin
        a_sx  = a[XLEN-1] & ((md_op == 3'd1) || (md_op == 3'd2));
        b_sx  = b[XLEN-1] & (md_op == 3'd1);
        mul_a = {{XLEN{a_sx}}, a};
        mul_b = {{XLEN{b_sx}}, b};
        prod  = mul_a * mul_b;
        mul_res = (md_op[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        if (!md_en)
            single_res = alu_res;
        else if (MD_EN != 0)
            single_res = mul_res;
        else
            single_res = '0;
    end

    // Divide operand preparation, one restoring step, and final sign fix-up
    always_comb begin
        sgn     = ~md_op[0];
        neg_a   = sgn & a[XLEN-1];
        neg_b   = sgn & b[XLEN-1];
        abs_a   = neg_a ? (~a + 1'b1) : a;
        abs_b   = neg_b ? (~b + 1'b1) : b;
        shifted = {dr, dq[XLEN-1]};
        ge      = shifted >= {1'b0, dd};
        diff    = shifted[XLEN-1:0] - dd;
        q_fix   = d_negq ? (~dq + 1'b1) : dq;
        r_fix   = d_negr ? (~dr + 1'b1) : dr;
        if (d_zero)
            fix_res = d_rem ? d_a : {XLEN{1'b1}};
        else if (d_ovf)
            fix_res = d_rem ? '0 : d_a;
        else
            fix_res = d_rem ? r_fix : q_fix;
    end

    // Control: FSM, step counter, result register and output handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            count     <= '0;
            out_valid <= 1'b0;
            result    <= '0;
        end else if (flush) begin
            state     <= S_IDLE;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && is_div) begin
                        state     <= S_DIV;
                        count     <= CW'(XLEN);
                        out_valid <= 1'b0;
                    end else if (accept) begin
                        result    <= single_res;
                        out_valid <= 1'b1;
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                S_DIV: begin
                    count <= count - 1'b1;
                    if (count == CW'(1))
                        state <= S_FIX;
                    if (out_valid && out_ready)
                        out_valid <= 1'b0;
                end
                S_FIX: begin
                    result    <= fix_res;
                    out_valid <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Divider datapath: latch operands on accept, then one step per DIV cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dq     <= '0;
            dr     <= '0;
            dd     <= '0;
            d_a    <= '0;
            d_negq <= 1'b0;
            d_negr <= 1'b0;
            d_rem  <= 1'b0;
            d_zero <= 1'b0;
            d_ovf  <= 1'b0;
        end else if (accept && is_div) begin
            dq     <= abs_a;
            dr     <= '0;
            dd     <= abs_b;
            d_a    <= a;
            d_negq <= neg_a ^ neg_b;
            d_negr <= neg_a;
            d_rem  <= md_op[1];
            d_zero <= (b == '0);
            d_ovf  <= sgn && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == {XLEN{1'b1}});
        end else if (state == S_DIV && !flush) begin
            dq <= {dq[XLEN-2:0], ge};
            dr <= ge ? diff : shifted[XLEN-1:0];
        end
    end

endmodule
